// File: rtl/cordic_vec.sv
// Pipelined vectoring-mode CORDIC: converts signed I/Q into a 32-bit phase (2^32 = 2*pi) and a magnitude.
// Define CORDIC_VEC_MAG_COMP_EN to add a 1/K gain-compensation stage (latency STAGES+3 instead of STAGES+2).
module cordic_vec #(
  parameter int IN_W   = 16,
  parameter int GUARD  = 4,
  parameter int STAGES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic signed [IN_W-1:0] i_i,
  input  logic signed [IN_W-1:0] q_i,
  output logic [31:0]            phase_o,
  output logic [IN_W:0]          mag_o,
  output logic                   valid_o
);

  localparam int W = IN_W + GUARD + 2;

  // atan(2^-k) scaled so that 2^32 corresponds to one full turn
  function automatic logic [31:0] atan_lut(input int k);
    logic [31:0] a;
    case (k)
      0:       a = 32'h2000_0000;
      1:       a = 32'h12E4_051E;
      2:       a = 32'h09FB_385B;
      3:       a = 32'h0511_11D4;
      4:       a = 32'h028B_0D43;
      5:       a = 32'h0145_D7E1;
      6:       a = 32'h00A2_F61E;
      7:       a = 32'h0051_7C55;
      8:       a = 32'h0028_BE53;
      9:       a = 32'h0014_5F2F;
      10:      a = 32'h000A_2F98;
      11:      a = 32'h0005_17CC;
      12:      a = 32'h0002_8BE6;
      13:      a = 32'h0001_45F3;
      14:      a = 32'h0000_A2FA;
      15:      a = 32'h0000_517D;
      default: a = 32'h0000_0000;
    endcase
    return a;
  endfunction

  logic signed [W-1:0] x_pipe [0:STAGES];
  logic signed [W-1:0] y_pipe [0:STAGES];
  logic signed [31:0]  z_pipe [0:STAGES];
  logic [STAGES:0]     v_pipe;

  logic signed [W-1:0] x_next [0:STAGES-1];
  logic signed [W-1:0] y_next [0:STAGES-1];
  logic signed [31:0]  z_next [0:STAGES-1];

  // Pre-rotation folds the left half-plane onto the right one; W has headroom so -2^(IN_W-1) negates cleanly
  logic signed [W-1:0] i_sh;
  logic signed [W-1:0] q_sh;
  logic                i_neg;
  logic signed [W-1:0] x_pre;
  logic signed [W-1:0] y_pre;
  logic signed [31:0]  z_pre;

  assign i_sh  = W'(i_i) <<< GUARD;
  assign q_sh  = W'(q_i) <<< GUARD;
  assign i_neg = i_i[IN_W-1];
  assign x_pre = i_neg ? -i_sh : i_sh;
  assign y_pre = i_neg ? -q_sh : q_sh;
  // The quadrant base is carried in z from the start; the sum base + z is the same modulo 2^32
  assign z_pre = i_neg ? 32'sh8000_0000 : 32'sh0000_0000;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam logic signed [31:0] ANG = atan_lut(gi);
      logic y_neg;
      assign y_neg = y_pipe[gi][W-1];
      assign x_next[gi] = y_neg ? x_pipe[gi] - (y_pipe[gi] >>> gi)
                                : x_pipe[gi] + (y_pipe[gi] >>> gi);
      assign y_next[gi] = y_neg ? y_pipe[gi] + (x_pipe[gi] >>> gi)
                                : y_pipe[gi] - (x_pipe[gi] >>> gi);
      assign z_next[gi] = y_neg ? z_pipe[gi] - ANG : z_pipe[gi] + ANG;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    x_pipe[0] <= x_pre;
    y_pipe[0] <= y_pre;
    z_pipe[0] <= z_pre;
    for (int k = 0; k < STAGES; k++) begin
      x_pipe[k+1] <= x_next[k];
      y_pipe[k+1] <= y_next[k];
      z_pipe[k+1] <= z_next[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[STAGES-1:0], valid_i};
    end
  end

  logic [IN_W:0] mag_raw;
  logic [31:0]   ph_last;
  logic [IN_W:0] mag_last;
  logic          v_last;

  assign mag_raw = x_pipe[STAGES][GUARD+IN_W:GUARD];

`ifdef CORDIC_VEC_MAG_COMP_EN
  localparam logic [15:0] INV_GAIN = 16'h9B75;

  logic [31:0]      ph_mid;
  logic [IN_W:0]    mag_mid;
  logic             v_mid;
  logic [IN_W+16:0] prod;

  always_ff @(posedge clk_i) begin
    ph_mid  <= z_pipe[STAGES];
    mag_mid <= mag_raw;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_mid <= 1'b0;
    end else begin
      v_mid <= v_pipe[STAGES];
    end
  end

  assign prod     = (IN_W+17)'(mag_mid) * (IN_W+17)'(INV_GAIN);
  assign ph_last  = ph_mid;
  assign mag_last = prod[IN_W+16:16];
  assign v_last   = v_mid;

  logic unused_bits;
  assign unused_bits = ^{x_pipe[STAGES][W-1], x_pipe[STAGES][GUARD-1:0], y_pipe[STAGES], prod[15:0]};
`else
  assign ph_last  = z_pipe[STAGES];
  assign mag_last = mag_raw;
  assign v_last   = v_pipe[STAGES];

  logic unused_bits;
  assign unused_bits = ^{x_pipe[STAGES][W-1], x_pipe[STAGES][GUARD-1:0], y_pipe[STAGES]};
`endif

  // Results only move when a valid slot emerges, so they hold through gaps
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      phase_o <= '0;
      mag_o   <= '0;
    end else begin
      valid_o <= v_last;
      if (v_last) begin
        phase_o <= ph_last;
        mag_o   <= mag_last;
      end
    end
  end

endmodule

// File: doc/cordic_vec.md
Name: cordic_vec

Overview:
- Pipelined CORDIC in vectoring mode; the inverse of the NCO-side rotation CORDIC.
- Takes a complex baseband sample (I/Q) and returns its phase and magnitude.
- Phase uses the same convention as the rotation CORDIC's phase input (2^32 = 2π), so results feed straight back into the NCO/phase path.
- Sits after the downconverter/decimator, feeding FM/PM demodulation and AGC magnitude detection.

Parameters:
- IN_W, 16, width of signed I/Q inputs (two's complement).
- GUARD, 4, fractional guard bits appended to I/Q inside the datapath.
- STAGES, 16, number of micro-rotation stages, legal range 8..16.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  sample strobe; i_i/q_i sampled when high.
- i_i  input  IN_W  signed in-phase sample.
- q_i  input  IN_W  signed quadrature sample.
- phase_o  output  32  unsigned phase; 0x4000_0000 = π/2; wraps mod 2^32.
- mag_o  output  IN_W+1  unsigned magnitude.
- valid_o  output  1  result strobe.

Behaviour:
- Reset is asynchronous and active-high; it clears the valid pipeline, valid_o, phase_o and mag_o to 0. Datapath registers need no reset.
- Internal x/y width: W = IN_W+GUARD+2 bits, signed. Internal z width: 32 bits, signed.
- Stage P (pre-rotation, registered):
  - if i_i >= 0: x = i, y = q, base = 0x0000_0000;
  - else: x = -i, y = -q, base = 0x8000_0000.
  - I/Q are sign-extended and shifted left by GUARD. z = 0.
  - i_i = -2^(IN_W-1) must negate without overflow (W has headroom).
- Stage k, k = 0..STAGES-1 (one register each):
  - if y >= 0: x += y>>>k; y -= x>>>k; z += ATAN[k];
  - else: x -= y>>>k; y += x>>>k; z -= ATAN[k].
  - Both updates use the pre-stage x/y values (arithmetic shifts).
  - ATAN[k] = round(atan(2^-k) * 2^32 / 2π), giving ATAN[0] = 0x2000_0000, ATAN[1] = 0x12E4_051E, ATAN[2] = 0x09FB_385B, … (identical constant set to the rotation CORDIC).
- Output stage (registered):
  - phase_o = base + z, modulo 2^32 (z is negative for the fourth quadrant, e.g. -π/4 → 0xE000_0000).
  - mag_o = x >> GUARD, truncated, unsigned.
  - Raw mag_o carries the CORDIC gain K ≈ 1.64676. Max value is 2^(IN_W-1)·√2·1.6468 < 2^(IN_W+1), so no saturation is needed.
- Latency: exactly STAGES+2 cycles from valid_i to valid_o (18 at default).
- Throughput: one sample per cycle; back-to-back valid_i is supported with no bubbles.
- Validity tracking:
  - A valid bit shifts alongside the data.
  - phase_o/mag_o update only when the emerging slot is valid; otherwise they hold their last value.
  - valid_o is high for exactly one cycle per input sample.
- i = q = 0: mag_o = 0; phase_o is unspecified but deterministic. No X may propagate.
- Reset mid-stream: all in-flight samples are discarded. After deassertion, valid_o stays 0 until a new sample has traversed the full latency.

Optional Feature:
- Macro: CORDIC_VEC_MAG_COMP_EN.
- Defined:
  - Adds one extra pipeline stage that multiplies the truncated magnitude by 0x9B75 (1/K in Q0.16) and shifts right by 16, truncating.
  - mag_o then approximates √(i²+q²) directly.
  - Latency becomes STAGES+3; phase_o is delayed to stay aligned with mag_o.
- Undefined: raw gain-K magnitude; latency STAGES+2.
- Port list and widths are identical in both builds.

Test Plan:
- Axes: i=16384, q=0 / i=0, q=16384 / i=-16384, q=0 / i=0, q=-16384, back-to-back.
  - Required phase_o: 0x0000_0000, 0x4000_0000, 0x8000_0000, 0xC000_0000, each ±0x0001_0000.
  - Required mag_o: 26981±3 raw (16384±3 with COMP_EN).
  - valid_o is four consecutive cycles starting 18 cycles (19 with COMP_EN) after the first input.
- Diagonals: i=q=±23170, all four sign combinations.
  - Required phase_o: 0x2000_0000, 0x6000_0000, 0xA000_0000, 0xE000_0000, each ±0x0001_0000.
  - Required mag_o: ≈53962 raw (32768±4 compensated).
- Extremes: i=-32768, q=0 → phase_o 0x8000_0000±0x0001_0000, mag_o 53962±4 raw, no overflow. i=32767, q=-32768 → no wrap error in x.
- Gapped valid: valid_i pattern 1,0,0,1,1.
  - valid_o reproduces the same pattern delayed by the latency.
  - Outputs hold their values during the gaps.
- Reset: assert rst_i asynchronously (mid-cycle) while 10 samples are in flight.
  - valid_o, phase_o and mag_o go to 0 immediately.
  - No valid_o occurs after release until a new sample completes.
- Random sweep: 10k random I/Q vs. a floating-point model.
  - Phase error ≤ 2^16 LSB.
  - Magnitude error ≤ 4 LSB, in both macro builds.
